thr_sweep_ctl: RTL and testbench
================================

// Module: thr_sweep_ctl
// PURPOSE
//  Threshold-sweep sequencer for the measure unit.
//  Steps the comparator DAC code from start to stop. At each code it waits for the DAC write and settle time.
//  It then requests N strobes from stb_gen and counts comparator ones. Each (code, count) pair goes out on a valid/ready port.
//  Sits in the wb_clk_i domain between the Wishbone register file, the DAC SPI masters and the stb_gen strobe handshake.
// PARAMETERS
//  CODE_W      16     DAC code width
//  CNT_W       16     sample-count / hit-count width
//  SETTLE_CYC  64     idle cycles after DAC rdy before the first strobe request (>=1)
//  TMO_W       20     strobe timeout counter width; timeout = 2**TMO_W-1 cycles
// PORTS
//  clk_i        in   1      clock; one clock for the whole block
//  arstn_i      in   1      reset, asynchronous, active-low
//  run_i        in   1      level; 0->1 in IDLE starts sweep, low at any time aborts
//  start_i      in   CODE_W first code
//  stop_i       in   CODE_W last code (inclusive bound)
//  step_i       in   CODE_W code increment (0 treated as 1)
//  samples_i    in   CNT_W  strobes per code (0 treated as 1)
//  dac_code_o   out  CODE_W code driven to both DAC SPI masters
//  dac_wre_o    out  1      one-cycle write pulse
//  dac_rdy_i    in   1      AND of dac1/dac2 rdy
//  stb_req_o    out  1      strobe request to stb_gen
//  stb_valid_i  in   1      strobe fired; cmp_out_i valid this cycle
//  cmp_out_i    in   1      comparator output, already synchronous to clk_i
//  res_code_o   out  CODE_W result code
//  res_cnt_o    out  CNT_W  ones counted at res_code_o
//  res_valid_o  out  1      result valid, held until res_ready_i
//  res_ready_i  in   1      result consumer ready
//  busy_o       out  1      not IDLE/DONE/ERR
//  done_o       out  1      sweep complete, held until run_i low
//  err_o        out  1      strobe timeout, held until run_i low
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0.
//  IDLE: on run_i rising edge (registered run_q), latch start/stop/step/samples.
//    Set code=start_i, go LOAD. Config inputs are ignored outside IDLE.
//  LOAD: wait dac_rdy_i=1, then present dac_code_o=code and pulse dac_wre_o for one cycle.
//    Go WAIT_DAC. dac_code_o holds its value until the next LOAD.
//  WAIT_DAC: ignore dac_rdy_i for 2 cycles (SPI master drops rdy), then wait for dac_rdy_i=1.
//    Go SETTLE and clear hits/taken.
//  SETTLE: count SETTLE_CYC cycles, then go REQ.
//  REQ: assert stb_req_o and start the timeout counter.
//    On stb_valid_i=1: hits+=cmp_out_i (saturating at all-ones), taken+=1, deassert stb_req_o next cycle, go GAP.
//    Timeout expiry: go ERR.
//  GAP: wait stb_valid_i=0. If taken==samples go PUSH, else go REQ.
//    No back-to-back sampling of the same strobe.
//  PUSH: res_valid_o=1, res_code_o=code, res_cnt_o=hits.
//    On res_valid_o&res_ready_i: compute nxt=code+step in CODE_W+1 bits.
//    If nxt>stop or nxt overflows: go DONE. Else code=nxt[CODE_W-1:0], go LOAD.
//    Backpressure stalls the sweep indefinitely; no data is lost.
//  start_i>stop_i: exactly one point at start_i, then DONE.
//  DONE: done_o=1. ERR: err_o=1. Both return to IDLE when run_i=0.
//  Abort: run_i=0 in any busy state -> IDLE next cycle.
//    stb_req_o, res_valid_o and dac_wre_o go 0 that cycle. dac_code_o keeps its last value.
//    An SPI transfer already in flight completes on its own.
//  Result latency: first result is valid no earlier than 2+SPI+2+SETTLE_CYC+samples strobes after start.
//  Reset mid-sweep: immediate return to reset values.
//    A pending DAC write completes in the SPI master.
// STRUCTURE
//  measure_pkg: typedef enum sweep_state_t {IDLE,LOAD,WAIT_DAC,SETTLE,REQ,GAP,PUSH,DONE,ERR}.
//    measure_pkg also holds the DAC_CODE_W=16 constant, shared with measure_unit.
//  Sub-module dac_load_seq: LOAD/WAIT_DAC/SETTLE sequencing (wre pulse, rdy mask, settle counter).
//    Its interface is go_i/code_i -> done_o.
//  Sweep FSM, hit counter, timeout counter and result register stay in thr_sweep_ctl.
// TESTING
//  1 start=100 stop=103 step=1 samples=4, cmp=1 on every 2nd strobe
//    -> 4 results (100,2),(101,2),(102,2),(103,2), then done_o=1.
//  2 start=0xFFF0 stop=0xFFFF step=8 -> codes 0xFFF0,0xFFF8, then done_o. No wrap to 0x0000.
//  3 step=0 samples=0 start=5 stop=6 -> codes 5,6, each with exactly 1 strobe.
//  4 Hold res_ready_i=0 for 500 cycles in PUSH -> res_valid_o stays 1.
//    No dac_wre_o and no stb_req_o during the stall. Results resume in order.
//  5 stb_valid_i stuck 0 -> err_o=1 after 2**TMO_W-1 cycles in REQ. run_i=0 -> IDLE, err_o=0.
//  6 run_i dropped mid-SETTLE and mid-REQ -> IDLE next cycle with stb_req_o=0.
//    Re-run restarts from start_i with the counters cleared.

Source files
------------

// File: rtl/measure_pkg.sv
// Shared measure-unit types: sweep state encoding and DAC code width.
// Imported by the threshold-sweep sequencer and its DAC load helper.
package measure_pkg;

    localparam int DAC_CODE_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        WAIT_DAC,
        SETTLE,
        REQ,
        GAP,
        PUSH,
        DONE,
        ERR
    } sweep_state_t;

endpackage

// File: rtl/thr_sweep_ctl_if.sv
// Result port of the threshold sweep: (code, hit count) with valid/ready.
// The sequencer drives the master side, the result consumer the slave side.
interface thr_sweep_ctl_if #(
    parameter int CODE_W = 16,
    parameter int CNT_W  = 16
);

    logic [CODE_W-1:0] res_code_o;
    logic [CNT_W-1:0]  res_cnt_o;
    logic              res_valid_o;
    logic              res_ready_i;

    modport master (
        output res_code_o,
        output res_cnt_o,
        output res_valid_o,
        input  res_ready_i
    );

    modport slave (
        input  res_code_o,
        input  res_cnt_o,
        input  res_valid_o,
        output res_ready_i
    );

endinterface

// File: rtl/dac_load_seq.sv
// DAC load helper: write pulse, rdy mask while the SPI master picks up
// the write, then a fixed settle interval before reporting done.
module dac_load_seq
    import measure_pkg::*;
#(
    parameter int CODE_W     = DAC_CODE_W,
    parameter int SETTLE_CYC = 64
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              go_i,
    input  logic              abort_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              dac_rdy_i,
    output logic [CODE_W-1:0] dac_code_o,
    output logic              dac_wre_o,
    output logic              done_o
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

    sweep_state_t      ph, ph_n;
    logic [1:0]        mask;
    logic [SW-1:0]     cnt;
    logic              wre_q;
    logic [CODE_W-1:0] code_q;
    logic              load_fire;

    assign load_fire  = (ph == LOAD) && dac_rdy_i && !abort_i;
    assign dac_code_o = code_q;
    assign dac_wre_o  = wre_q && !abort_i;

    // Phase register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) ph <= IDLE;
        else          ph <= ph_n;
    end

    // Phase sequencing and settle completion
    always_comb begin
        ph_n   = ph;
        done_o = 1'b0;
        if (abort_i) begin
            ph_n = IDLE;
        end else begin
            case (ph)
                IDLE:     if (go_i) ph_n = LOAD;
                LOAD:     if (dac_rdy_i) ph_n = WAIT_DAC;
                WAIT_DAC: if (mask == 2'd0 && dac_rdy_i) ph_n = SETTLE;
                SETTLE: begin
                    if (cnt == SET_LAST) begin
                        done_o = 1'b1;
                        ph_n   = IDLE;
                    end
                end
                default:  ph_n = IDLE;
            endcase
        end
    end

    // Write pulse, held code, rdy mask and settle counter
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wre_q  <= 1'b0;
            code_q <= '0;
            mask   <= 2'd0;
            cnt    <= '0;
        end else begin
            wre_q <= load_fire;
            if (load_fire) code_q <= code_i;
            if (load_fire)          mask <= 2'd2;
            else if (mask != 2'd0)  mask <= mask - 2'd1;
            if (ph == SETTLE && !abort_i) cnt <= cnt + 1'b1;
            else                          cnt <= '0;
        end
    end

endmodule

// File: rtl/thr_sweep_ctl.sv
// Threshold-sweep sequencer: steps the comparator DAC code, collects
// N strobes per code, and emits (code, ones count) on the result port.
module thr_sweep_ctl
    import measure_pkg::*;
#(
    parameter int CODE_W     = DAC_CODE_W,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 64,
    parameter int TMO_W      = 20
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              run_i,
    input  logic [CODE_W-1:0] start_i,
    input  logic [CODE_W-1:0] stop_i,
    input  logic [CODE_W-1:0] step_i,
    input  logic [CNT_W-1:0]  samples_i,
    output logic [CODE_W-1:0] dac_code_o,
    output logic              dac_wre_o,
    input  logic              dac_rdy_i,
    output logic              stb_req_o,
    input  logic              stb_valid_i,
    input  logic              cmp_out_i,
    thr_sweep_ctl_if.master   res,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    sweep_state_t      state, state_n;
    logic              run_q;
    logic              run_rise;
    logic [CODE_W-1:0] stop_q, step_q, code_q;
    logic [CNT_W-1:0]  samp_q, hits, taken;
    logic [TMO_W-1:0]  tmo;
    logic [CODE_W:0]   nxt;
    logic              last;
    logic              go;
    logic              seq_done;

    assign run_rise = run_i && !run_q;
    assign nxt      = {1'b0, code_q} + {1'b0, step_q};
    assign last     = nxt > {1'b0, stop_q};
    assign go       = (state == LOAD);

    assign stb_req_o       = run_i && (state == REQ);
    assign res.res_valid_o = run_i && (state == PUSH);
    assign res.res_code_o  = code_q;
    assign res.res_cnt_o   = hits;
    assign busy_o = !(state inside {IDLE, DONE, ERR});
    assign done_o = (state == DONE);
    assign err_o  = (state == ERR);

    dac_load_seq #(
        .CODE_W    (CODE_W),
        .SETTLE_CYC(SETTLE_CYC)
    ) u_load (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .go_i      (go),
        .abort_i   (!run_i),
        .code_i    (code_q),
        .dac_rdy_i (dac_rdy_i),
        .dac_code_o(dac_code_o),
        .dac_wre_o (dac_wre_o),
        .done_o    (seq_done)
    );

    // Sweep state register and run edge detector
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state <= IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_n;
            run_q <= run_i;
        end
    end

    // Sweep next-state; run low returns any non-idle state to IDLE
    always_comb begin
        state_n = state;
        if (state != IDLE && !run_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (run_rise) state_n = LOAD;
                LOAD: if (seq_done) state_n = REQ;
                REQ: begin
                    if (stb_valid_i)          state_n = GAP;
                    else if (tmo == TMO_LAST) state_n = ERR;
                end
                GAP: begin
                    if (!stb_valid_i)
                        state_n = (taken == samp_q) ? PUSH : REQ;
                end
                PUSH: begin
                    if (res.res_ready_i)
                        state_n = last ? DONE : LOAD;
                end
                default: state_n = state;
            endcase
        end
    end

    // Config latch, code stepping, hit/taken counters, strobe timeout
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            stop_q <= '0;
            step_q <= '0;
            samp_q <= '0;
            code_q <= '0;
            hits   <= '0;
            taken  <= '0;
            tmo    <= '0;
        end else begin
            if (state == REQ && run_i) tmo <= tmo + 1'b1;
            else                       tmo <= '0;
            if (state == IDLE && run_rise) begin
                stop_q <= stop_i;
                step_q <= (step_i == '0) ? CODE_W'(1) : step_i;
                samp_q <= (samples_i == '0) ? CNT_W'(1) : samples_i;
                code_q <= start_i;
                hits   <= '0;
                taken  <= '0;
            end
            if (state == LOAD && seq_done) begin
                hits  <= '0;
                taken <= '0;
            end
            if (state == REQ && run_i && stb_valid_i) begin
                taken <= taken + 1'b1;
                if (cmp_out_i && hits != '1) hits <= hits + 1'b1;
            end
            if (state == PUSH && run_i && res.res_ready_i && !last)
                code_q <= nxt[CODE_W-1:0];
        end
    end

endmodule

// File: tb/tb_thr_sweep_ctl.sv
// Bench for thr_sweep_ctl: DAC/strobe/consumer models plus a sweep
// reference built from start/stop/step/samples and the strobes sent.
module tb_thr_sweep_ctl;

    localparam int CW = 16;
    localparam int NW = 16;
    localparam int SC = 8;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [CW-1:0] start, stop, step;
    logic [NW-1:0] samp;
    logic [CW-1:0] dac_code;
    logic          dac_wre, dac_rdy;
    logic          stb_req, stb_valid, cmp;
    logic          busy, done, err;

    thr_sweep_ctl_if #(.CODE_W(CW), .CNT_W(NW)) rif ();

    thr_sweep_ctl #(
        .CODE_W(CW), .CNT_W(NW), .SETTLE_CYC(SC), .TMO_W(TW)
    ) dut (
        .clk_i(clk), .arstn_i(rst_n), .run_i(run),
        .start_i(start), .stop_i(stop), .step_i(step),
        .samples_i(samp), .dac_code_o(dac_code),
        .dac_wre_o(dac_wre), .dac_rdy_i(dac_rdy),
        .stb_req_o(stb_req), .stb_valid_i(stb_valid),
        .cmp_out_i(cmp), .res(rif), .busy_o(busy),
        .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    int dac_busy = 0;
    int stb_dly  = 0;
    int stb_hold = 0;
    bit stb_en   = 1;
    int cmp_mode = 0;
    int ready_mode = 0;
    int samp_eff = 1;

    bit fired[$];
    int dac_log[$];
    int got_code[$];
    int got_cnt[$];
    int exp_code[$];

    // Behavioural DAC SPI master, strobe generator and result consumer
    always @(negedge clk) begin
        if (dac_wre) begin
            dac_log.push_back(int'(dac_code));
            dac_busy = $urandom_range(3, 6);
        end else if (dac_busy > 0) begin
            dac_busy--;
        end
        dac_rdy = (dac_busy == 0);

        if (stb_hold > 0) begin
            stb_hold--;
            if (stb_hold == 0) stb_valid = 1'b0;
        end else if (stb_req && stb_en) begin
            if (stb_dly > 0) begin
                stb_dly--;
            end else begin
                if (cmp_mode == 0)
                    cmp = ((fired.size() % samp_eff) % 2) == 1;
                else
                    cmp = 1'($urandom_range(0, 1));
                fired.push_back(cmp);
                stb_valid = 1'b1;
                stb_hold  = $urandom_range(1, 2);
                stb_dly   = $urandom_range(0, 3);
            end
        end
        if (!stb_valid) cmp = 1'($urandom_range(0, 1));

        case (ready_mode)
            0:       rif.res_ready_i = 1'b1;
            1:       rif.res_ready_i = 1'($urandom_range(0, 1));
            default: rif.res_ready_i = 1'b0;
        endcase
        if (rif.res_valid_o && rif.res_ready_i) begin
            got_code.push_back(int'(rif.res_code_o));
            got_cnt.push_back(int'(rif.res_cnt_o));
        end
    end

    // Expected code list from the sweep rules
    function automatic void build_exp(input int s, input int e, input int st);
        int c;
        int d;
        c = s;
        d = (st == 0) ? 1 : st;
        exp_code.delete();
        forever begin
            exp_code.push_back(c);
            c += d;
            if (c > e) break;
        end
    endfunction

    // Expected ones count for result i from the strobes actually sent
    function automatic int exp_hits(input int i);
        int sum;
        sum = 0;
        for (int j = 0; j < samp_eff; j++)
            if (i * samp_eff + j < fired.size())
                sum += int'(fired[i * samp_eff + j]);
        return sum;
    endfunction

    task automatic start_run(input int s, input int e, input int st, input int n);
        @(posedge clk); #1;
        start = CW'(s);
        stop  = CW'(e);
        step  = CW'(st);
        samp  = NW'(n);
        samp_eff = (n == 0) ? 1 : n;
        fired.delete();
        dac_log.delete();
        got_code.delete();
        got_cnt.delete();
        run = 1'b1;
    endtask

    task automatic stop_run();
        @(posedge clk); #1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_end(output bit to);
        to = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (done || err) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_req(output bit to);
        to = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (stb_req) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run = 1'b0;
        start = '0; stop = '0; step = '0; samp = '0;
        dac_rdy = 1'b1; stb_valid = 1'b0; cmp = 1'b0;
        rif.res_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dac_wre, stb_req, rif.res_valid_o} !== 3'b000) begin
            fails++;
            $display("FAIL reset_strobes got=%b want=000",
                     {dac_wre, stb_req, rif.res_valid_o});
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_status got=%b want=000", {busy, done, err});
        end
        checks++;
        if (dac_code !== '0 || rif.res_code_o !== '0 || rif.res_cnt_o !== '0) begin
            fails++;
            $display("FAIL reset_data dac=%0d code=%0d cnt=%0d want=0",
                     dac_code, rif.res_code_o, rif.res_cnt_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_sweep(input string name, input int s, input int e,
                              input int st, input int n, input int rmode);
        bit to;
        ready_mode = rmode;
        build_exp(s, e, st);
        start_run(s, e, st, n);
        wait_end(to);
        checks++;
        if (to || done !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s_done timeout=%0d done=%b err=%b want done=1",
                     name, to, done, err);
        end
        checks++;
        if (got_code.size() != exp_code.size()) begin
            fails++;
            $display("FAIL %s_nres got=%0d want=%0d",
                     name, got_code.size(), exp_code.size());
        end
        for (int i = 0; i < got_code.size() && i < exp_code.size(); i++) begin
            checks++;
            if (got_code[i] != exp_code[i] || got_cnt[i] != exp_hits(i)) begin
                fails++;
                $display("FAIL %s_res[%0d] got=(%0d,%0d) want=(%0d,%0d)", name,
                         i, got_code[i], got_cnt[i], exp_code[i], exp_hits(i));
            end
        end
        checks++;
        if (fired.size() != exp_code.size() * samp_eff) begin
            fails++;
            $display("FAIL %s_strobes got=%0d want=%0d", name,
                     fired.size(), exp_code.size() * samp_eff);
        end
        checks++;
        if (dac_log.size() != exp_code.size()) begin
            fails++;
            $display("FAIL %s_nwrites got=%0d want=%0d", name,
                     dac_log.size(), exp_code.size());
        end
        for (int i = 0; i < dac_log.size() && i < exp_code.size(); i++) begin
            checks++;
            if (dac_log[i] != exp_code[i]) begin
                fails++;
                $display("FAIL %s_dac[%0d] got=%0d want=%0d", name, i,
                         dac_log[i], exp_code[i]);
            end
        end
        stop_run();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_release done=%b busy=%b want 0,0", name, done, busy);
        end
    endtask

    task automatic test_basic();
        cmp_mode = 0;
        test_sweep("basic", 100, 103, 1, 4, 0);
        checks++;
        if (got_cnt.size() != 4) begin
            fails++;
            $display("FAIL basic_count got=%0d want=4", got_cnt.size());
        end
        for (int i = 0; i < got_cnt.size(); i++) begin
            checks++;
            if (got_cnt[i] != 2 || got_code[i] != 100 + i) begin
                fails++;
                $display("FAIL basic_pair[%0d] got=(%0d,%0d) want=(%0d,2)",
                         i, got_code[i], got_cnt[i], 100 + i);
            end
        end
    endtask

    task automatic test_top_edge();
        cmp_mode = 1;
        test_sweep("top", 'hFFF0, 'hFFFF, 8, 3, 1);
        checks++;
        if (got_code.size() != 2 || got_code[got_code.size()-1] != 'hFFF8) begin
            fails++;
            $display("FAIL top_nowrap n=%0d want 2 ending 0xFFF8", got_code.size());
        end
        test_sweep("reverse", 50, 10, 3, 2, 1);
    endtask

    task automatic test_zero_cfg();
        cmp_mode = 1;
        test_sweep("zero", 5, 6, 0, 0, 0);
        checks++;
        if (fired.size() != 2) begin
            fails++;
            $display("FAIL zero_strobes got=%0d want=2", fired.size());
        end
    endtask

    task automatic test_backpressure();
        bit to;
        bit seen;
        int bad;
        cmp_mode = 1;
        ready_mode = 2;
        build_exp(200, 204, 2);
        start_run(200, 204, 2, 3);
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            seen = rif.res_valid_o;
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL stall_first_valid got=0 want=1");
        end
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            checks++;
            if (rif.res_valid_o !== 1'b1 || dac_wre !== 1'b0 || stb_req !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold cyc=%0d valid=%b wre=%b req=%b want 1,0,0",
                         k, rif.res_valid_o, dac_wre, stb_req);
            end
        end
        ready_mode = 1;
        wait_end(to);
        checks++;
        if (to || got_code.size() != exp_code.size()) begin
            fails++;
            $display("FAIL stall_resume timeout=%0d n=%0d want n=%0d",
                     to, got_code.size(), exp_code.size());
        end
        for (int i = 0; i < got_code.size() && i < exp_code.size(); i++) begin
            checks++;
            if (got_code[i] != exp_code[i] || got_cnt[i] != exp_hits(i)) begin
                fails++;
                $display("FAIL stall_res[%0d] got=(%0d,%0d) want=(%0d,%0d)", i,
                         got_code[i], got_cnt[i], exp_code[i], exp_hits(i));
            end
        end
        stop_run();
    endtask

    task automatic test_timeout();
        int nreq;
        stb_en = 1'b0;
        ready_mode = 0;
        start_run(7, 9, 1, 2);
        nreq = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (err) break;
            if (stb_req) nreq++;
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL tmo_err err=%b busy=%b want 1,0", err, busy);
        end
        checks++;
        if (nreq != (1 << TW) - 1) begin
            fails++;
            $display("FAIL tmo_len got=%0d want=%0d", nreq, (1 << TW) - 1);
        end
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL tmo_clear err=%b busy=%b done=%b want 0", err, busy, done);
        end
        stb_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        bit to;
        bit seen;
        cmp_mode = 1;
        ready_mode = 0;
        start_run(30, 40, 1, 3);
        seen = 1'b0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            seen = dac_wre;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (dac_rdy) break;
        end
        repeat (3) @(posedge clk);
        #1;
        run = 1'b0;
        #1;
        checks++;
        if ({stb_req, rif.res_valid_o, dac_wre} !== 3'b000 || !seen) begin
            fails++;
            $display("FAIL abort_settle_now outs=%b wrote=%b want 000,1",
                     {stb_req, rif.res_valid_o, dac_wre}, seen);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || dac_code !== CW'(30)) begin
            fails++;
            $display("FAIL abort_settle_idle busy=%b dac=%0d want 0,30", busy, dac_code);
        end
        @(posedge clk); #1;

        stb_en = 1'b0;
        start_run(30, 40, 1, 3);
        wait_req(to);
        @(posedge clk); #1;
        run = 1'b0;
        #1;
        checks++;
        if (to || stb_req !== 1'b0) begin
            fails++;
            $display("FAIL abort_req_now timeout=%0d req=%b want 0", to, stb_req);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || stb_req !== 1'b0) begin
            fails++;
            $display("FAIL abort_req_idle busy=%b req=%b want 0,0", busy, stb_req);
        end
        stb_en = 1'b1;
        repeat (4) @(posedge clk);
        test_sweep("rerun", 30, 33, 1, 3, 1);
    endtask

    task automatic test_reset_mid();
        bit to;
        start_run(60, 70, 1, 2);
        wait_req(to);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (to || busy !== 1'b0 || stb_req !== 1'b0 || dac_code !== '0) begin
            fails++;
            $display("FAIL reset_mid timeout=%0d busy=%b req=%b dac=%0d want 0",
                     to, busy, stb_req, dac_code);
        end
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_random();
        int s, e, st, n;
        cmp_mode = 1;
        for (int r = 0; r < 4; r++) begin
            s  = $urandom_range(0, 300);
            e  = s + $urandom_range(0, 12);
            st = $urandom_range(0, 4);
            n  = $urandom_range(0, 5);
            test_sweep("random", s, e, st, n, 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_top_edge();
        test_zero_cfg();
        test_backpressure();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
